// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fpu_issue_ctrl
// Description : Issues fp16 requests to an FPU, waits for MUL/DIV completion
//               with timeout, and holds the captured response until consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_issue_ctrl #(
    parameter int MAX_WAIT = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [15:0] reqIn1,
    input  logic [15:0] reqIn2,
    input  logic [1:0]  reqOp,
    output logic [15:0] fpuIn1,
    output logic [15:0] fpuIn2,
    output logic [1:0]  fpuOp,
    output logic        fpuStart,
    input  logic [15:0] fpuOut,
    input  logic        mulDone,
    input  logic        divDone,
    input  logic [3:0]  condCodes,
    input  logic [4:0]  statusFlags,
    input  logic [2:0]  comps,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [15:0] rspResult,
    output logic [3:0]  rspCondCodes,
    output logic [4:0]  rspStatus,
    output logic [2:0]  rspComps,
    output logic        rspTimeout,
    output logic [4:0]  accFlags,
    input  logic        clearFlags,
    output logic        busy
);

    localparam logic [1:0]  c_OP_MUL   = 2'd2;
    localparam logic [15:0] c_QNAN     = 16'h7E00;
    localparam logic [4:0]  c_NV       = 5'b10000;
    localparam logic [7:0]  c_LAST_CNT = 8'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EVAL   = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_wait_cnt;
    logic [15:0] r_in1, r_in2;
    logic [1:0]  r_op;
    logic [15:0] r_result;
    logic [3:0]  r_cc;
    logic [4:0]  r_status;
    logic [2:0]  r_comps;
    logic        r_timeout;
    logic [4:0]  r_acc;

    logic        w_accept;
    logic        w_done;
    logic        w_cap_fpu;
    logic        w_cap_to;
    logic        w_capture;
    logic [4:0]  w_cap_status;
    logic [4:0]  w_acc_next;

    assign w_accept     = (r_state == S_IDLE) && reqValid;
    // Only the completion that matches the in-flight op is ever looked at.
    assign w_done       = (r_op == c_OP_MUL) ? mulDone : divDone;
    assign w_capture    = w_cap_fpu || w_cap_to;
    assign w_cap_status = w_cap_to ? c_NV : statusFlags;

    always_comb begin
        w_next    = r_state;
        w_cap_fpu = 1'b0;
        w_cap_to  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (reqValid) begin
                    w_next = reqOp[1] ? S_LAUNCH : S_EVAL;
                end
            end
            S_EVAL: begin
                w_cap_fpu = 1'b1;
                w_next    = S_HOLD;
            end
            S_LAUNCH: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                // A done in the final wait cycle takes priority over timeout.
                if (w_done) begin
                    w_cap_fpu = 1'b1;
                    w_next    = S_HOLD;
                end else if (r_wait_cnt == c_LAST_CNT) begin
                    w_cap_to = 1'b1;
                    w_next   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (rspReady) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_acc_next = r_acc;
        if (clearFlags) begin
            w_acc_next = w_capture ? w_cap_status : 5'b0;
        end else if (w_capture) begin
            w_acc_next = r_acc | w_cap_status;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_in1      <= 16'h0;
            r_in2      <= 16'h0;
            r_op       <= 2'd0;
            r_wait_cnt <= 8'd0;
            r_result   <= 16'h0;
            r_cc       <= 4'h0;
            r_status   <= 5'h0;
            r_comps    <= 3'h0;
            r_timeout  <= 1'b0;
            r_acc      <= 5'h0;
        end else begin
            if (w_accept) begin
                r_in1 <= reqIn1;
                r_in2 <= reqIn2;
                r_op  <= reqOp;
            end
            if (r_state == S_LAUNCH) begin
                r_wait_cnt <= 8'd0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_cap_fpu) begin
                r_result  <= fpuOut;
                r_cc      <= condCodes;
                r_status  <= statusFlags;
                r_comps   <= comps;
                r_timeout <= 1'b0;
            end else if (w_cap_to) begin
                r_result  <= c_QNAN;
                r_cc      <= 4'h0;
                r_status  <= c_NV;
                r_comps   <= 3'h0;
                r_timeout <= 1'b1;
            end
            r_acc <= w_acc_next;
        end
    end

    assign reqReady     = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign fpuStart     = (r_state == S_LAUNCH);
    assign rspValid     = (r_state == S_HOLD);
    assign fpuIn1       = r_in1;
    assign fpuIn2       = r_in2;
    assign fpuOp        = r_op;
    assign rspResult    = r_result;
    assign rspCondCodes = r_cc;
    assign rspStatus    = r_status;
    assign rspComps     = r_comps;
    assign rspTimeout   = r_timeout;
    assign accFlags     = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_issue_ctrl
// Description : Self-checking bench for fpu_issue_ctrl with an FPU stub and a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_issue_ctrl;

    localparam int MAX_WAIT = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        reqValid = 1'b0, reqReady;
    logic [15:0] reqIn1 = '0, reqIn2 = '0;
    logic [1:0]  reqOp = '0;
    logic [15:0] fpuIn1, fpuIn2;
    logic [1:0]  fpuOp;
    logic        fpuStart;
    logic [15:0] fpuOut = '0;
    logic        mulDone = 1'b0, divDone = 1'b0;
    logic [3:0]  condCodes = '0;
    logic [4:0]  statusFlags = '0;
    logic [2:0]  comps = '0;
    logic        rspValid, rspReady = 1'b0;
    logic [15:0] rspResult;
    logic [3:0]  rspCondCodes;
    logic [4:0]  rspStatus;
    logic [2:0]  rspComps;
    logic        rspTimeout;
    logic [4:0]  accFlags;
    logic        clearFlags = 1'b0;
    logic        busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [4:0]  acc_m = '0;
    logic [28:0] rsp_bus;

    assign rsp_bus = {rspResult, rspCondCodes, rspStatus, rspComps, rspTimeout};

    always #5 clock = ~clock;

    fpu_issue_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady),
        .reqIn1(reqIn1), .reqIn2(reqIn2), .reqOp(reqOp),
        .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .fpuOp(fpuOp), .fpuStart(fpuStart),
        .fpuOut(fpuOut), .mulDone(mulDone), .divDone(divDone),
        .condCodes(condCodes), .statusFlags(statusFlags), .comps(comps),
        .rspValid(rspValid), .rspReady(rspReady),
        .rspResult(rspResult), .rspCondCodes(rspCondCodes),
        .rspStatus(rspStatus), .rspComps(rspComps), .rspTimeout(rspTimeout),
        .accFlags(accFlags), .clearFlags(clearFlags), .busy(busy)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One complete request/response transaction; d is the WAIT cycle (1-based)
    // in which the FPU stub raises the matching done.
    task automatic run_txn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] res, input logic [4:0] st, input logic [3:0] cc,
                           input logic [2:0] cm, input int d, input bit stray,
                           input bit clr, input int hold);
        bit          is_md;
        bit          to_exp;
        int          exp_lat;
        logic [28:0] exp_rsp;
        int          start_cyc;
        int          starts;
        int          got;
        is_md     = op[1];
        to_exp    = is_md && (d > MAX_WAIT);
        exp_lat   = !is_md ? 2 : (to_exp ? MAX_WAIT + 2 : d + 2);
        exp_rsp   = to_exp ? {16'h7E00, 4'h0, 5'b10000, 3'b000, 1'b1} : {res, cc, st, cm, 1'b0};
        acc_m     = (clr && !is_md) ? exp_rsp[8:4] : (acc_m | exp_rsp[8:4]);
        start_cyc = -1;
        starts    = 0;
        got       = -1;

        n_cmp++;
        if (reqReady !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_in_idle: got %b want 1", reqReady);
        end
        reqValid = 1'b1; reqIn1 = a; reqIn2 = b; reqOp = op;
        fpuOut = res; condCodes = cc; statusFlags = st; comps = cm;
        if (stray && is_md) begin
            if (op == 2'd2) mulDone = 1'b1; else divDone = 1'b1;
        end
        step();
        reqValid = 1'b0; mulDone = 1'b0; divDone = 1'b0;
        reqIn1 = 16'($urandom); reqIn2 = 16'($urandom); reqOp = 2'($urandom);

        n_cmp++;
        if ({fpuIn1, fpuIn2, fpuOp, busy, reqReady} !== {a, b, op, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL operand_capture: got %h/%h op%0d busy%b rdy%b want %h/%h op%0d busy1 rdy0",
                     fpuIn1, fpuIn2, fpuOp, busy, reqReady, a, b, op);
        end

        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (fpuStart === 1'b1) begin
                starts++;
                if (start_cyc < 0) start_cyc = cyc;
            end
            if (rspValid === 1'b1) begin
                got = cyc;
                break;
            end
            mulDone = 1'b0;
            divDone = 1'b0;
            if (is_md && start_cyc >= 0) begin
                if (cyc == start_cyc + d || (stray && cyc == start_cyc)) begin
                    if (op == 2'd2) mulDone = 1'b1; else divDone = 1'b1;
                end
                if (stray && cyc == start_cyc + 2) begin
                    if (op == 2'd2) divDone = 1'b1; else mulDone = 1'b1;
                end
            end
            clearFlags = clr && !is_md && (cyc == 1);
            step();
        end
        mulDone = 1'b0; divDone = 1'b0; clearFlags = 1'b0;

        n_cmp++;
        if (got != exp_lat) begin
            n_bad++;
            $display("FAIL latency op%0d d%0d: got %0d want %0d", op, d, got, exp_lat);
        end
        n_cmp++;
        if (starts != (is_md ? 1 : 0)) begin
            n_bad++;
            $display("FAIL start_pulses op%0d: got %0d want %0d", op, starts, is_md ? 1 : 0);
        end
        n_cmp++;
        if (rsp_bus !== exp_rsp) begin
            n_bad++;
            $display("FAIL response op%0d d%0d: got %h want %h", op, d, rsp_bus, exp_rsp);
        end
        n_cmp++;
        if (accFlags !== acc_m) begin
            n_bad++;
            $display("FAIL acc_flags: got %b want %b", accFlags, acc_m);
        end

        // A decoy request is presented throughout HOLD and must never be taken.
        for (int h = 0; h < hold; h++) begin
            rspReady = 1'b0; reqValid = 1'b1; reqIn1 = ~a; reqIn2 = ~b;
            step();
            n_cmp++;
            if ({rspValid, reqReady, rsp_bus} !== {1'b1, 1'b0, exp_rsp}) begin
                n_bad++;
                $display("FAIL hold_stable cyc%0d: got v%b r%b %h want v1 r0 %h",
                         h, rspValid, reqReady, rsp_bus, exp_rsp);
            end
        end
        rspReady = 1'b1; reqValid = 1'b1; reqIn1 = ~a; reqIn2 = ~b;
        step();
        rspReady = 1'b0; reqValid = 1'b0;
        n_cmp++;
        if ({rspValid, busy, reqReady, fpuIn1, fpuIn2} !== {1'b0, 1'b0, 1'b1, a, b}) begin
            n_bad++;
            $display("FAIL release: got v%b b%b r%b %h/%h want v0 b0 r1 %h/%h",
                     rspValid, busy, reqReady, fpuIn1, fpuIn2, a, b);
        end
    endtask

    task automatic pulse_clear();
        clearFlags = 1'b1;
        step();
        clearFlags = 1'b0;
        acc_m = '0;
        n_cmp++;
        if (accFlags !== 5'b0) begin
            n_bad++;
            $display("FAIL clear_flags: got %b want 00000", accFlags);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if ({reqReady, busy, fpuStart, rspValid, fpuIn1, fpuIn2, fpuOp, rsp_bus, accFlags} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'd0, 29'h0, 5'h0}) begin
            n_bad++;
            $display("FAIL reset_state: got rdy%b busy%b st%b v%b %h %h %0d %h %b",
                     reqReady, busy, fpuStart, rspValid, fpuIn1, fpuIn2, fpuOp, rsp_bus, accFlags);
        end
        @(negedge clock);
        reset = 1'b1;
        step();
        n_cmp++;
        if ({reqReady, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL after_release: got rdy%b busy%b want rdy1 busy0", reqReady, busy);
        end
    endtask

    task automatic test_add();
        run_txn(2'd0, 16'h3C00, 16'h4000, 16'h4200, 5'b0, 4'h2, 3'b100, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_mul_stray();
        run_txn(2'd2, 16'h4000, 16'h4200, 16'h4600, 5'b0, 4'h1, 3'b001, 4, 1'b1, 1'b0, 1);
    endtask

    task automatic test_flags();
        pulse_clear();
        run_txn(2'd3, 16'h3C00, 16'h0000, 16'h7C00, 5'b01000, 4'h3, 3'b000, 3, 1'b0, 1'b0, 0);
        run_txn(2'd0, 16'h1234, 16'h0001, 16'h1235, 5'b00001, 4'h0, 3'b010, 0, 1'b0, 1'b0, 0);
        n_cmp++;
        if (accFlags !== 5'b01001) begin
            n_bad++;
            $display("FAIL acc_sticky: got %b want 01001", accFlags);
        end
        pulse_clear();
        // Clear coincident with a capture leaves only the captured status.
        run_txn(2'd1, 16'h5000, 16'h4000, 16'h4C00, 5'b00100, 4'h0, 3'b001, 0, 1'b0, 1'b1, 0);
    endtask

    task automatic test_timeout();
        run_txn(2'd3, 16'h3C00, 16'h4000, 16'h1111, 5'b00001, 4'hF, 3'b111, 99, 1'b0, 1'b0, 0);
        run_txn(2'd3, 16'h3C00, 16'h4000, 16'h3800, 5'b00000, 4'h4, 3'b010, MAX_WAIT, 1'b0, 1'b0, 0);
        run_txn(2'd2, 16'h3C00, 16'h4000, 16'h2222, 5'b00010, 4'h4, 3'b010, MAX_WAIT + 1, 1'b1, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        run_txn(2'd0, 16'hABCD, 16'h1357, 16'h2468, 5'b00010, 4'h5, 3'b100, 0, 1'b0, 1'b0, 5);
        run_txn(2'd2, 16'h4400, 16'h4400, 16'h4C80, 5'b00001, 4'h6, 3'b001, 2, 1'b0, 1'b0, 5);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_txn(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 16'($urandom),
                    5'($urandom), 4'($urandom), 3'($urandom), int'($urandom_range(1, MAX_WAIT + 2)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        run_txn(2'd0, 16'h0101, 16'h0202, 16'h0303, 5'b00110, 4'h1, 3'b010, 0, 1'b0, 1'b0, 0);
        reqValid = 1'b1; reqOp = 2'd3; reqIn1 = 16'h4000; reqIn2 = 16'h3C00;
        step();
        reqValid = 1'b0;
        n_cmp++;
        if (fpuStart !== 1'b1) begin
            n_bad++;
            $display("FAIL launch_pulse: got %b want 1", fpuStart);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({fpuStart, busy, rspValid} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_in_launch: got st%b busy%b v%b want 000", fpuStart, busy, rspValid);
        end
        @(negedge clock);
        reset = 1'b1;
        step();
        reqValid = 1'b1; reqOp = 2'd2; reqIn1 = 16'h4200; reqIn2 = 16'h4200;
        step();
        reqValid = 1'b0;
        step();
        step();
        #2 reset = 1'b0;
        #1;
        acc_m = '0;
        n_cmp++;
        if ({rspValid, busy, accFlags, fpuIn1, rsp_bus} !== {1'b0, 1'b0, 5'h0, 16'h0, 29'h0}) begin
            n_bad++;
            $display("FAIL reset_in_wait: got v%b busy%b acc%b in1 %h rsp %h want all zero",
                     rspValid, busy, accFlags, fpuIn1, rsp_bus);
        end
        @(negedge clock);
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 14; c++) begin
            mulDone = 1'($urandom_range(0, 1));
            divDone = 1'($urandom_range(0, 1));
            step();
            if (rspValid === 1'b1 || busy === 1'b1) seen++;
        end
        mulDone = 1'b0; divDone = 1'b0;
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL abandoned_response: got %0d active cycles want 0", seen);
        end
        run_txn(2'd2, 16'h3C00, 16'h3C00, 16'h3C00, 5'b00000, 4'h2, 3'b010, 1, 1'b0, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul_stray();
        test_flags();
        test_timeout();
        test_backpressure();
        test_random();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
